// File: rtl/snk68_sound_pkg.sv
// Shared constants and types for the 68k <-> Z80 sound command/response latches.
package snk68_sound_pkg;

  typedef logic [7:0] latch_byte_t;
  typedef logic [7:0] nmi_cnt_t;

  localparam int          NMI_PULSE_DEFAULT = 16;
  localparam latch_byte_t LATCH_RESET_VAL   = 8'h00;

endpackage

// File: rtl/sound_latch_bridge_if.sv
// Bus signals between the 68k/Z80 address decode and the sound latch bridge.
interface sound_latch_bridge_if;
  import snk68_sound_pkg::*;

  logic        m68k_latch_cs;
  logic        z80_latch_read_cs;
  logic        m68k_uds_n;
  logic [15:0] m68k_din;
  logic [15:0] m68k_dout;
  logic        z80_latch_cs;
  logic        z80_rd_n;
  logic        z80_wr_n;
  latch_byte_t z80_din;
  latch_byte_t z80_dout;
  logic        z80_nmi_n;
  logic        cmd_pending;
  logic        rsp_pending;

  modport master (
    output m68k_latch_cs, z80_latch_read_cs, m68k_uds_n, m68k_din,
           z80_latch_cs, z80_rd_n, z80_wr_n, z80_din,
    input  m68k_dout, z80_dout, z80_nmi_n, cmd_pending, rsp_pending
  );

  modport slave (
    input  m68k_latch_cs, z80_latch_read_cs, m68k_uds_n, m68k_din,
           z80_latch_cs, z80_rd_n, z80_wr_n, z80_din,
    output m68k_dout, z80_dout, z80_nmi_n, cmd_pending, rsp_pending
  );

endinterface

// File: rtl/strobe_rise.sv
// One-flop rising-edge detector producing a single-cycle pulse per select assertion.
module strobe_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic i_level,
    output logic o_pulse
);

    // The flop remembers "level was low last cycle" and clears to 0, so a
    // select already high when reset releases is never seen as a new edge.
    logic r_was_low;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_was_low <= 1'b0;
        end else begin
            r_was_low <= ~i_level;
        end
    end

    assign o_pulse = i_level & r_was_low;

endmodule

// File: rtl/sound_latch_bridge.sv
// Command latch (68k -> Z80, with NMI pulse) and response latch (Z80 -> 68k).
module sound_latch_bridge
    import snk68_sound_pkg::*;
#(
    parameter int NMI_PULSE = NMI_PULSE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sound_latch_bridge_if.slave  bus
);

    localparam nmi_cnt_t NMI_LOAD = nmi_cnt_t'(NMI_PULSE);

    logic        w_cmd_wr_lvl;
    logic        w_cmd_rd_lvl;
    logic        w_rsp_wr_lvl;
    logic        w_cmd_wr;
    logic        w_cmd_rd;
    logic        w_rsp_wr;
    logic        w_rsp_rd;
    logic        w_unused_din_lo;

    latch_byte_t r_cmd;
    latch_byte_t r_rsp;
    logic        r_cmd_pending;
    logic        r_rsp_pending;
    nmi_cnt_t    r_nmi_cnt;

    assign w_cmd_wr_lvl    = bus.m68k_latch_cs & ~bus.m68k_uds_n;
    assign w_cmd_rd_lvl    = bus.z80_latch_cs  & ~bus.z80_rd_n;
    assign w_rsp_wr_lvl    = bus.z80_latch_cs  & ~bus.z80_wr_n;
    assign w_unused_din_lo = ^bus.m68k_din[7:0];

    strobe_rise u_cmd_wr (.clk(clk), .reset_n(reset_n), .i_level(w_cmd_wr_lvl),          .o_pulse(w_cmd_wr));
    strobe_rise u_cmd_rd (.clk(clk), .reset_n(reset_n), .i_level(w_cmd_rd_lvl),          .o_pulse(w_cmd_rd));
    strobe_rise u_rsp_wr (.clk(clk), .reset_n(reset_n), .i_level(w_rsp_wr_lvl),          .o_pulse(w_rsp_wr));
    strobe_rise u_rsp_rd (.clk(clk), .reset_n(reset_n), .i_level(bus.z80_latch_read_cs), .o_pulse(w_rsp_rd));

    // Command path: a write wins over a same-cycle read so fresh data stays flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd         <= LATCH_RESET_VAL;
            r_cmd_pending <= 1'b0;
        end else if (w_cmd_wr) begin
            r_cmd         <= bus.m68k_din[15:8];
            r_cmd_pending <= 1'b1;
        end else if (w_cmd_rd) begin
            r_cmd_pending <= 1'b0;
        end
    end

    // Reloading mid-pulse keeps the counter non-zero, so the NMI just stretches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nmi_cnt <= '0;
        end else if (w_cmd_wr) begin
            r_nmi_cnt <= NMI_LOAD;
        end else if (r_nmi_cnt != '0) begin
            r_nmi_cnt <= r_nmi_cnt - nmi_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp         <= LATCH_RESET_VAL;
            r_rsp_pending <= 1'b0;
        end else if (w_rsp_wr) begin
            r_rsp         <= bus.z80_din;
            r_rsp_pending <= 1'b1;
        end else if (w_rsp_rd) begin
            r_rsp_pending <= 1'b0;
        end
    end

    assign bus.z80_dout    = r_cmd;
    assign bus.m68k_dout   = {r_rsp, r_rsp};
    assign bus.z80_nmi_n   = (r_nmi_cnt == '0);
    assign bus.cmd_pending = r_cmd_pending;
    assign bus.rsp_pending = r_rsp_pending;

endmodule

// File: doc/sound_latch_bridge.md
SOUND_LATCH_BRIDGE -- requirements
Module: sound_latch_bridge

Interface
REQ-001 Parameter NMI_PULSE, default 16, sets the Z80 NMI low time in clk cycles (legal range 1..255).
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 m68k_latch_cs  in  1  68k write select for the sound command latch (0x080000).
REQ-005 z80_latch_read_cs  in  1  68k read select for the response latch (0x0f8000).
REQ-006 m68k_uds_n  in  1  68k upper data strobe, active low.
REQ-007 m68k_din  in  16  68k write data; the command byte is [15:8].
REQ-008 m68k_dout  out  16  response latch value, driven as {rsp, rsp}.
REQ-009 z80_latch_cs  in  1  Z80 select for 0xf800.
REQ-010 z80_rd_n / z80_wr_n  in  1 each  Z80 read and write strobes, active low.
REQ-011 z80_din  in  8  Z80 write data.
REQ-012 z80_dout  out  8  command latch value.
REQ-013 z80_nmi_n  out  1  Z80 NMI request, active low.
REQ-014 cmd_pending / rsp_pending  out  1 each  unread-data flags, for debug and status.

Function
REQ-015 The block SHALL define the command write event as the rising edge of (m68k_latch_cs & !m68k_uds_n), detected against the previous-cycle value; the event SHALL fire once per bus cycle, regardless of how long the select is held.
REQ-016 On a command write event, the block SHALL load cmd with m68k_din[15:8], set cmd_pending, and load the NMI counter with NMI_PULSE.
REQ-017 z80_nmi_n SHALL be 0 while the NMI counter is non-zero; the counter SHALL decrement once per cycle; the first low cycle is the cycle after the write event.
REQ-018 A command write event while the NMI counter is non-zero SHALL reload the counter to NMI_PULSE, giving one extended pulse and no high glitch.
REQ-019 The Z80 command read event is the rising edge of (z80_latch_cs & !z80_rd_n); it SHALL clear cmd_pending.
REQ-020 z80_dout SHALL equal cmd combinationally at all times, with zero latency.
REQ-021 The Z80 response write event is the rising edge of (z80_latch_cs & !z80_wr_n); it SHALL load rsp with z80_din and set rsp_pending.
REQ-022 The 68k response read event is the rising edge of z80_latch_read_cs; it SHALL clear rsp_pending.
REQ-023 m68k_dout SHALL equal {rsp, rsp} combinationally.
REQ-024 Simultaneous command write and Z80 command read in the same cycle: new data is stored and cmd_pending SHALL remain 1.
REQ-025 Simultaneous response write and 68k response read in the same cycle: new data is stored and rsp_pending SHALL remain 1.
REQ-026 An overwrite of an unread latch SHALL be allowed silently: the new data replaces the old and the pending flag stays 1.
REQ-027 Command writes with m68k_uds_n high (lower-byte-only writes) SHALL be ignored.
REQ-028 The command path and the response path SHALL be independent; no event on one path SHALL alter the state of the other.

Reset
REQ-029 While reset_n=0, all of the following SHALL hold immediately, without waiting for a clock edge:
- cmd=0x00 and rsp=0x00
- cmd_pending=0 and rsp_pending=0
- NMI counter=0, so z80_nmi_n=1
- all edge-detect history registers=0
REQ-030 A select held high across reset release SHALL NOT generate an event, because the history registers are cleared to 0 while the select is already high.
- Consequence: a reset asserted mid-pulse ends the NMI at once, and the pulse does not resume after reset release.

Structure
REQ-031 A shared package snk68_sound_pkg SHALL hold:
- NMI_PULSE_DEFAULT (16)
- LATCH_RESET_VAL (0x00)
- the latch byte type
REQ-032 The block SHALL use a single sub-module, strobe_rise, for all four event detectors. It has one flop, takes clk, reset_n and a level input, and outputs a one-cycle pulse.
REQ-033 The NMI counter SHALL be 8 bits wide.

Verification
REQ-034 68k write 0xA5 with uds_n=0, select held 4 cycles -> z80_dout=0xA5, cmd_pending=1, z80_nmi_n low for exactly 16 cycles, one event only.
REQ-035 A second write of 0x3C at pulse cycle 10 -> z80_nmi_n stays low for 16 more cycles (26 total), z80_dout=0x3C.
REQ-036 Z80 read of 0xf800 in the same cycle as a 68k write of 0x77 -> cmd=0x77, cmd_pending=1.
REQ-037 Z80 write 0x5A to 0xf800, then 68k read of 0x0f8000 -> m68k_dout=0x5A5A, rsp_pending goes 1 then 0.
REQ-038 reset_n asserted at pulse cycle 5 with cmd=0x11 and the select held high through reset release:
- z80_nmi_n=1 and cmd=0x00 immediately on assertion
- no new NMI and no new event after release
REQ-039 68k write with uds_n=1 and m68k_din=0xFFFF -> cmd unchanged, no NMI.
